// File: rtl/instr_fetch_unit.sv
// Purpose : instruction fetch unit; owns the 64-bit PC, fetches over a req/ack memory port, issues IR to control.
// Latency : ir_valid rises 1 cycle after mem_req for zero-wait memory, +1 cycle per memory wait cycle.
// Backpr. : ir_ready low in ISSUE holds IR/PC/outputs and keeps mem_req low; peak rate 1 instr per 2 cycles.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   mem_req/mem_addr      read request and address (address is always PC)
//   mem_ack/mem_rdata     read completion and instruction word
//   IR/ir_valid/ir_ready  instruction handed to the control unit, retired on ir_ready
//   PS/pc_in/offset       next-PC select and operands, sampled on retire
//   PC, retired_count     current program counter, number of retired instructions
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] IR,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic [2:0]  PS,
  input  logic [63:0] pc_in,
  input  logic [63:0] offset,
  output logic [63:0] PC,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] next_pc;

  // Branch targets are word aligned, so the low bits of pc_in and the top
  // bits of the word offset (shifted out by the x4 scaling) never matter.
  logic unused_bits;
  assign unused_bits = ^{pc_in[1:0], offset[63:62]};

  // Next PC as selected by the control word; only consumed on retire.
  always_comb begin
    next_pc = PC + 64'd4;
    case (PS)
      3'b000:  next_pc = PC;
      3'b001:  next_pc = PC + 64'd4;
      3'b010:  next_pc = {pc_in[63:2], 2'b00};
      3'b011:  next_pc = PC + {offset[61:0], 2'b00};
      default: next_pc = PC + 64'd4;  // reserved codes behave as sequential
    endcase
  end

  assign mem_addr = PC;

  // mem_req and ir_valid are flops updated together with the state so that
  // no input reaches an output combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_REQ;
      mem_req       <= 1'b1;
      ir_valid      <= 1'b0;
      PC            <= RESET_PC;
      IR            <= 32'h0;
      retired_count <= 32'h0;
    end else begin
      case (state)
        S_REQ, S_WAIT: begin
          if (mem_ack) begin
            IR       <= mem_rdata;
            state    <= S_ISSUE;
            mem_req  <= 1'b0;
            ir_valid <= 1'b1;
          end else begin
            state    <= S_WAIT;
          end
        end
        S_ISSUE: begin
          // mem_ack is ignored here: no request is open.
          if (ir_ready) begin
            PC            <= next_pc;
            retired_count <= retired_count + 32'd1;
            state         <= S_REQ;
            mem_req       <= 1'b1;
            ir_valid      <= 1'b0;
          end
        end
        default: begin
          state    <= S_REQ;
          mem_req  <= 1'b1;
          ir_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose : self-checking bench for instr_fetch_unit: memory model, PC reference model, scoreboard monitor.
// Latency : checks ir_valid timing against the memory wait count chosen for each fetch.
// Backpr. : drives ir_ready stalls with spurious acks and checks the held outputs.
module tb_instr_fetch_unit;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] IR;
  logic        ir_valid;
  logic        ir_ready;
  logic [2:0]  PS;
  logic [63:0] pc_in;
  logic [63:0] offset;
  logic [63:0] PC;
  logic [31:0] retired_count;

  instr_fetch_unit #(.RESET_PC(64'h0)) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .IR           (IR),
    .ir_valid     (ir_valid),
    .ir_ready     (ir_ready),
    .PS           (PS),
    .pc_in        (pc_in),
    .offset       (offset),
    .PC           (PC),
    .retired_count(retired_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ir;
    logic [31:0] cnt;
  } item_t;

  item_t       exp_q[$];
  logic [31:0] mem[logic [63:0]];
  logic [63:0] model_pc;
  logic [31:0] model_cnt;
  int          tests = 0;
  int          fails = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Instruction memory: each address gets a random word on first touch and
  // keeps it, so refetching an address returns the same instruction.
  function automatic logic [31:0] mem_word(logic [63:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Reference next-PC rule, written with plain arithmetic.
  function automatic logic [63:0] model_next(logic [63:0] pc, logic [2:0] ps,
                                             logic [63:0] tgt, logic [63:0] off);
    case (ps)
      3'd0:    return pc;
      3'd2:    return tgt - (tgt % 64'd4);
      3'd3:    return pc + off * 64'd4;
      default: return pc + 64'd4;
    endcase
  endfunction

  // Monitor: every new ir_valid assertion pops one expected instruction;
  // while it stays valid, IR and PC must not move.
  initial begin
    item_t cur;
    logic  prev_valid;
    prev_valid = 1'b0;
    cur = '{pc: 64'h0, ir: 32'h0, cnt: 32'h0};
    forever begin
      @(posedge clock);
      #1;
      if (ir_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 64'd1, 64'd0);
        end else begin
          cur = exp_q.pop_front();
          check("issue_ir", IR, cur.ir);
          check("issue_pc", PC, cur.pc);
          check("issue_count", retired_count, cur.cnt);
        end
      end else if (ir_valid && prev_valid) begin
        check("hold_ir", IR, cur.ir);
        check("hold_pc", PC, cur.pc);
      end
      prev_valid = ir_valid;
    end
  end

  // Called at a negedge; asserts reset and checks the asynchronous effect
  // before any clock edge, then releases on a later negedge.
  task automatic apply_reset();
    reset   = 1'b1;
    mem_ack = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 64'd1);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_ir_valid", ir_valid, 64'd0);
    check("rst_ir", IR, 64'h0);
    check("rst_count", retired_count, 64'd0);
    model_pc  = 64'h0;
    model_cnt = 32'h0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Serve one fetch with w wait cycles. Called at a negedge.
  task automatic fetch(int w);
    int n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!mem_req) begin
      check("fetch_timeout", 64'd0, 64'd1);
      return;
    end
    check("req_addr", mem_addr, model_pc);
    for (int i = 0; i < w; i++) begin
      mem_ack  = 1'b0;
      ir_ready = 1'($urandom);  // ignored outside ISSUE
      @(negedge clock);
      check("wait_req", mem_req, 64'd1);
      check("wait_valid", ir_valid, 64'd0);
      check("wait_addr", mem_addr, model_pc);
    end
    mem_ack   = 1'b1;
    mem_rdata = mem_word(model_pc);
    exp_q.push_back('{pc: model_pc, ir: mem_rdata, cnt: model_cnt});
    ir_ready  = 1'($urandom);
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    ir_ready  = 1'b0;
    check("issue_latency", ir_valid, 64'd1);
    check("issue_req_low", mem_req, 64'd0);
  endtask

  // Retire the presented instruction after 'hold' stall cycles. Called at a negedge.
  task automatic retire(logic [2:0] ps, logic [63:0] tgt, logic [63:0] off,
                        int hold, bit spurious);
    if (!ir_valid) begin
      check("retire_not_valid", 64'd0, 64'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      ir_ready  = 1'b0;
      mem_ack   = spurious && (i == hold / 2);
      mem_rdata = $urandom;
      @(negedge clock);
      check("stall_req", mem_req, 64'd0);
      check("stall_valid", ir_valid, 64'd1);
      check("stall_pc", PC, model_pc);
    end
    mem_ack   = 1'b0;
    ir_ready  = 1'b1;
    PS        = ps;
    pc_in     = tgt;
    offset    = off;
    model_pc  = model_next(model_pc, ps, tgt, off);
    model_cnt = model_cnt + 32'd1;
    @(negedge clock);
    ir_ready = 1'($urandom);
    PS       = 3'($urandom);
    pc_in    = {$urandom, $urandom};
    offset   = {$urandom, $urandom};
    check("retire_valid_low", ir_valid, 64'd0);
    check("retire_req", mem_req, 64'd1);
    check("retire_addr", mem_addr, model_pc);
    check("retire_count", retired_count, model_cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    ir_ready  = 1'b0;
    PS        = 3'd0;
    pc_in     = 64'h0;
    offset    = 64'h0;
    mem[64'h0] = 32'h8B010050;
    apply_reset();

    // Zero-wait first fetch, then a sequential stream with 3 wait cycles.
    fetch(0);
    retire(3'd1, 64'h0, 64'h0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      fetch(3);
      retire(3'd1, 64'h0, 64'h0, 0, 1'b0);
    end
    check("four_retires", retired_count, 64'd4);

    // Branches: backward offset, register target, wrap past 2^64.
    fetch(0); retire(3'd3, 64'h0, -64'sd2, 0, 1'b0);
    check("branch_back", mem_addr, 64'd8);
    fetch(1); retire(3'd2, 64'h1003, 64'h0, 0, 1'b0);
    check("branch_reg", mem_addr, 64'h1000);
    fetch(0); retire(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 1'b0);
    fetch(2); retire(3'd3, 64'h0, 64'd1, 0, 1'b0);
    check("branch_wrap", mem_addr, 64'h0);

    // Backpressure with a spurious ack while no request is open.
    fetch(0); retire(3'd1, 64'h0, 64'h0, 10, 1'b1);

    // Reset while waiting on memory at PC=40.
    fetch(0); retire(3'd2, 64'd40, 64'h0, 0, 1'b0);
    mem_ack = 1'b0;
    repeat (2) @(negedge clock);
    check("wait_pc40", mem_addr, 64'd40);
    apply_reset();
    fetch(1); retire(3'd1, 64'h0, 64'h0, 0, 1'b0);

    // Reset while an instruction is presented.
    fetch(0);
    apply_reset();
    fetch(0); retire(3'd2, 64'd20, 64'h0, 0, 1'b0);

    // Hold (refetch same word) and a reserved PS code.
    fetch(0); retire(3'd0, 64'h0, 64'h0, 0, 1'b0);
    check("hold_addr", mem_addr, 64'd20);
    fetch(1); retire(3'd5, 64'h0, 64'h0, 0, 1'b0);
    check("reserved_ps", mem_addr, 64'd24);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      int          k;
      logic [2:0]  ps;
      k  = int'($urandom_range(0, 64)) - 32;
      ps = 3'($urandom);
      fetch(int'($urandom_range(0, 3)));
      retire(ps, {$urandom, $urandom}, 64'(longint'(k)),
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (3) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
